// File: rtl/bus_arbiter.sv
// Round-robin owner arbitration for the shared serial bus.
// Masters shift in a slave ID; the arbiter grants one owner at a time.
module bus_arbiter #(
    parameter int NO_MASTERS = 2,
    parameter int NO_SLAVES  = 3,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [0:NO_MASTERS-1]            cmd_M,
    output logic [0:NO_MASTERS-1]            grant_M,
    output logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_state,
    input  logic                             ready
);

    typedef enum logic [2:0] {R_IDLE, R_ADDR, R_PEND, R_OWN, R_DROP} rx_t;
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arb_t;

    rx_t                   rx_q  [NO_MASTERS];
    rx_t                   rx_d  [NO_MASTERS];
    logic [S_ID_WIDTH-1:0] cnt_q [NO_MASTERS];
    logic [S_ID_WIDTH-1:0] cnt_d [NO_MASTERS];
    logic [S_ID_WIDTH-1:0] id_q  [NO_MASTERS];
    logic [S_ID_WIDTH-1:0] id_d  [NO_MASTERS];

    arb_t                    st_q, st_d;
    logic [M_ID_WIDTH-1:0]   owner_q, owner_d;
    logic [M_ID_WIDTH-1:0]   rr_q, rr_d;
    logic [0:NO_MASTERS-1]   grant_d;
    logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_d;

    logic [0:NO_MASTERS-1] pend;
    logic [0:NO_MASTERS-1] grant_evt;
    logic                  found;
    logic [M_ID_WIDTH-1:0] pick_m;
    logic                  rel_evt;

    // A master that drops cmd while pending is not eligible this cycle.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        pick_m = '0;
        for (int i = 0; i < NO_MASTERS; i++)
            pend[i] = (rx_q[i] == R_PEND) && cmd_M[i];
        for (int o = 0; o < NO_MASTERS; o++) begin
            idx = (int'(rr_q) + o) % NO_MASTERS;
            if (!found && pend[idx]) begin
                found  = 1'b1;
                pick_m = M_ID_WIDTH'(idx);
            end
        end
        for (int i = 0; i < NO_MASTERS; i++)
            grant_evt[i] = (st_q == IDLE) && found &&
                           (pick_m == M_ID_WIDTH'(i));
        rel_evt = ((st_q == BUSY) && !cmd_M[owner_q] && ready) ||
                  ((st_q == RELEASE) && ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NO_MASTERS; i++) begin
                rx_q[i]  <= R_IDLE;
                cnt_q[i] <= '0;
                id_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NO_MASTERS; i++) begin
                rx_q[i]  <= rx_d[i];
                cnt_q[i] <= cnt_d[i];
                id_q[i]  <= id_d[i];
            end
        end
    end

    always_comb begin
        logic [S_ID_WIDTH:0] ext;
        ext = '0;
        for (int i = 0; i < NO_MASTERS; i++) begin
            rx_d[i]  = rx_q[i];
            cnt_d[i] = cnt_q[i];
            id_d[i]  = id_q[i];
            case (rx_q[i])
                R_IDLE: begin
                    if (cmd_M[i]) begin
                        rx_d[i]  = R_ADDR;
                        cnt_d[i] = '0;
                    end
                end
                R_ADDR: begin
                    ext      = {id_q[i], cmd_M[i]};
                    id_d[i]  = ext[S_ID_WIDTH-1:0];
                    cnt_d[i] = cnt_q[i] + 1'b1;
                    if (int'(cnt_q[i]) == S_ID_WIDTH - 1) begin
                        if (id_d[i] != '0 && int'(id_d[i]) <= NO_SLAVES)
                            rx_d[i] = R_PEND;
                        else
                            rx_d[i] = R_DROP;
                    end
                end
                R_PEND: begin
                    if (!cmd_M[i])
                        rx_d[i] = R_IDLE;
                    else if (grant_evt[i])
                        rx_d[i] = R_OWN;
                end
                R_OWN: begin
                    if (rel_evt && owner_q == M_ID_WIDTH'(i))
                        rx_d[i] = R_IDLE;
                end
                R_DROP: begin
                    if (!cmd_M[i])
                        rx_d[i] = R_IDLE;
                end
                default: rx_d[i] = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= IDLE;
            owner_q   <= '0;
            rr_q      <= '0;
            grant_M   <= '0;
            bus_state <= '0;
        end else begin
            st_q      <= st_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            grant_M   <= grant_d;
            bus_state <= bus_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE:    if (found) st_d = BUSY;
            BUSY:    if (!cmd_M[owner_q]) st_d = ready ? IDLE : RELEASE;
            RELEASE: if (ready) st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and owner bookkeeping.
    always_comb begin
        owner_d = owner_q;
        rr_d    = rr_q;
        grant_d = grant_M;
        bus_d   = bus_state;
        if (st_q == IDLE && found) begin
            owner_d         = pick_m;
            rr_d            = M_ID_WIDTH'((int'(pick_m) + 1) % NO_MASTERS);
            grant_d         = '0;
            grant_d[pick_m] = 1'b1;
            bus_d           = {pick_m, id_q[pick_m]};
        end else if (rel_evt) begin
            grant_d = '0;
            bus_d   = '0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [0:1] cmd;
    logic [0:1] grant;
    logic [2:0] bus;
    logic       ready;

    int checks;
    int failures;

    bus_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_M     (cmd),
        .grant_M   (grant),
        .bus_state (bus),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start bit and two ID bits (MSB first), then holds cmd high.
    task automatic frame(input logic [0:1] en, input logic [1:0] id0,
                         input logic [1:0] id1);
        logic [1:0] ids [2];
        ids[0] = id0;
        ids[1] = id1;
        for (int b = 0; b < 3; b++) begin
            for (int m = 0; m < 2; m++)
                if (en[m]) cmd[m] = (b == 0) ? 1'b1 : ids[m][2-b];
            tick();
        end
        for (int m = 0; m < 2; m++)
            if (en[m]) cmd[m] = 1'b1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        cmd   = 2'b00;
        ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus !== 3'b000) begin
            failures++;
            $display("FAIL reset_bus got=%b want=000", bus);
        end
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL reset_grant got=%b want=00", grant);
        end
    endtask

    task automatic test_single();
        frame(2'b10, 2'b10, 2'b00);
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL single_early got=%b want=00", grant);
        end
        tick();
        checks++;
        if (grant !== 2'b10 || bus !== 3'b010) begin
            failures++;
            $display("FAIL single_grant got=%b/%b want=10/010", grant, bus);
        end
        cmd[0] = 1'b0;
        ready  = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b00 || bus !== 3'b000) begin
            failures++;
            $display("FAIL single_release got=%b/%b want=00/000", grant, bus);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        frame(2'b11, 2'b01, 2'b11);
        tick();
        checks++;
        if (grant !== 2'b10 || bus !== 3'b001) begin
            failures++;
            $display("FAIL sim_first got=%b/%b want=10/001", grant, bus);
        end
        cmd[0] = 1'b0;
        tick();
        checks++;
        if (grant !== 2'b00 || bus !== 3'b000) begin
            failures++;
            $display("FAIL sim_gap got=%b/%b want=00/000", grant, bus);
        end
        tick();
        checks++;
        if (grant !== 2'b01 || bus !== 3'b111) begin
            failures++;
            $display("FAIL sim_second got=%b/%b want=01/111", grant, bus);
        end
        cmd[1] = 1'b0;
        tick();
        frame(2'b11, 2'b01, 2'b11);
        tick();
        checks++;
        if (grant !== 2'b10 || bus !== 3'b001) begin
            failures++;
            $display("FAIL sim_rr_again got=%b/%b want=10/001", grant, bus);
        end
        cmd[0] = 1'b0;
        tick();
        tick();
        checks++;
        if (grant !== 2'b01 || bus !== 3'b111) begin
            failures++;
            $display("FAIL sim_rr_m1 got=%b/%b want=01/111", grant, bus);
        end
        cmd[1] = 1'b0;
        tick();
    endtask

    task automatic test_busy_slave();
        frame(2'b11, 2'b01, 2'b10);
        tick();
        checks++;
        if (grant !== 2'b10 || bus !== 3'b001) begin
            failures++;
            $display("FAIL busy_grant got=%b/%b want=10/001", grant, bus);
        end
        cmd[0] = 1'b0;
        ready  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (grant !== 2'b10 || bus !== 3'b001) begin
                failures++;
                $display("FAIL busy_hold cyc=%0d got=%b/%b want=10/001",
                         c, grant, bus);
            end
        end
        ready = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b00 || bus !== 3'b000) begin
            failures++;
            $display("FAIL busy_clear got=%b/%b want=00/000", grant, bus);
        end
        tick();
        checks++;
        if (grant !== 2'b01 || bus !== 3'b110) begin
            failures++;
            $display("FAIL busy_next got=%b/%b want=01/110", grant, bus);
        end
        cmd[1] = 1'b0;
        tick();
    endtask

    task automatic test_invalid_id();
        frame(2'b01, 2'b00, 2'b00);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (grant !== 2'b00 || bus !== 3'b000) begin
                failures++;
                $display("FAIL invalid_nogrant cyc=%0d got=%b/%b want=00/000",
                         c, grant, bus);
            end
        end
        cmd[1] = 1'b0;
        tick();
        frame(2'b01, 2'b00, 2'b11);
        tick();
        checks++;
        if (grant !== 2'b01 || bus !== 3'b111) begin
            failures++;
            $display("FAIL invalid_recover got=%b/%b want=01/111", grant, bus);
        end
        cmd[1] = 1'b0;
        tick();
    endtask

    task automatic test_withdraw();
        frame(2'b10, 2'b01, 2'b00);
        tick();
        checks++;
        if (grant !== 2'b10 || bus !== 3'b001) begin
            failures++;
            $display("FAIL wd_owner got=%b/%b want=10/001", grant, bus);
        end
        frame(2'b01, 2'b00, 2'b10);
        cmd[1] = 1'b0;
        tick();
        cmd[0] = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (grant !== 2'b00 || bus !== 3'b000) begin
            failures++;
            $display("FAIL wd_after_release got=%b/%b want=00/000", grant, bus);
        end
        // Withdraw exactly on the edge where the arbiter would select.
        frame(2'b01, 2'b00, 2'b10);
        cmd[1] = 1'b0;
        tick();
        tick();
        checks++;
        if (grant !== 2'b00 || bus !== 3'b000) begin
            failures++;
            $display("FAIL wd_same_edge got=%b/%b want=00/000", grant, bus);
        end
    endtask

    task automatic test_reset_mid();
        frame(2'b10, 2'b11, 2'b00);
        tick();
        checks++;
        if (grant !== 2'b10 || bus !== 3'b011) begin
            failures++;
            $display("FAIL rstmid_owner got=%b/%b want=10/011", grant, bus);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 2'b00 || bus !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_async got=%b/%b want=00/000", grant, bus);
        end
        cmd = 2'b00;
        tick();
        #2;
        rst = 1'b0;
        tick();
        frame(2'b01, 2'b00, 2'b01);
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_early got=%b want=00", grant);
        end
        tick();
        checks++;
        if (grant !== 2'b01 || bus !== 3'b101) begin
            failures++;
            $display("FAIL rstmid_regrant got=%b/%b want=01/101", grant, bus);
        end
        cmd[1] = 1'b0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        cmd      = 2'b00;
        ready    = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_busy_slave();
        test_invalid_id();
        test_withdraw();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
